// File: rtl/qmac_seq.sv
// qmac_seq: pipelined signed Q-format multiply-accumulate with round, saturate and valid/ready output
module qmac_seq #(
    parameter int N = 16,
    parameter int Q = 8,
    parameter int G = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_a,
    input  logic signed [N-1:0] in_b,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic        [N-1:0] out_y,
    output logic                out_overflow
);
    localparam int AW = 2*N+G;
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW:0] Y_MAX = {{(AW-N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW:0] Y_MIN = {{(AW-N+2){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (Q-1);
    logic signed [2*N-1:0] prod_q, prod_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [N-1:0] y_q, y_d;
    logic v_s1_q, v_s1_d, last_s1_q, last_s1_d, last_s2_q, last_s2_d;
    logic sticky_q, sticky_d, out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [AW:0] sum, rnd, r;
    logic accept, acc_ovf, r_hi, r_lo;
    assign in_ready     = !(last_s1_q || last_s2_q || (out_valid_q && !out_ready));
    assign out_valid    = out_valid_q;
    assign out_y        = y_q;
    assign out_overflow = ovf_q;
    always_comb begin
        accept      = in_valid && in_ready;
        prod_d      = accept ? in_a * in_b : prod_q;
        v_s1_d      = accept;
        last_s1_d   = accept && in_last;
        last_s2_d   = last_s1_q;
        // one extra bit exposes accumulator overflow as a sign disagreement
        sum         = (AW+1)'(acc_q) + (AW+1)'(prod_q);
        acc_ovf     = sum[AW] != sum[AW-1];
        acc_d       = last_s2_q ? '0 :
                      !v_s1_q   ? acc_q :
                      acc_ovf   ? (sum[AW] ? ACC_MIN : ACC_MAX) : sum[AW-1:0];
        sticky_d    = last_s2_q ? 1'b0 : sticky_q || (v_s1_q && acc_ovf);
        rnd         = (AW+1)'(acc_q) + HALF;
        r           = rnd >>> Q;
        r_hi        = r > Y_MAX;
        r_lo        = r < Y_MIN;
        y_d         = !last_s2_q ? y_q :
                      r_hi ? Y_MAX[N-1:0] : r_lo ? Y_MIN[N-1:0] : r[N-1:0];
        ovf_d       = last_s2_q ? (sticky_q || r_hi || r_lo) : ovf_q;
        out_valid_d = last_s2_q || (out_valid_q && !out_ready);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            v_s1_q      <= 1'b0;
            last_s1_q   <= 1'b0;
            last_s2_q   <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            v_s1_q      <= v_s1_d;
            last_s1_q   <= last_s1_d;
            last_s2_q   <= last_s2_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: doc/qmac_seq.md
Name: qmac_seq

Overview:
- Pipelined signed fixed-point multiply-accumulate engine for the GRU/LSTM gate datapath.
- Sequentially consumes one (a, b) pair per beat and accumulates the full-precision products of a vector.
- On the vector's last beat, rounds and saturates the sum to Q-format N bits and presents it on a valid/ready output.
- Successor to the combinational qmult: adds accumulation, rounding, a sticky overflow flag, a pipeline and backpressure.

Parameters:
- N, 16, data word width (two's complement), N >= 4.
- Q, 8, fractional bits of inputs and output, 1 <= Q <= N-2.
- G, 8, accumulator guard bits; accumulator width AW = 2N+G.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present on in_a/in_b/in_last.
- in_ready  out  1  engine accepts the beat this cycle.
- in_a  in  N  signed Q-format operand.
- in_b  in  N  signed Q-format operand.
- in_last  in  1  beat is the final element of the vector.
- out_valid  out  1  result held on out_y/out_overflow.
- out_ready  in  1  consumer takes the result this cycle.
- out_y  out  N  signed Q-format dot-product result.
- out_overflow  out  1  result was clamped (accumulator or output saturation).

Behaviour:
- Reset (rst=1 at an edge): all pipeline valid/last flags cleared, accumulator=0, sticky flag=0, out_valid=0, out_y=0, out_overflow=0.
- Reset mid-vector discards the partial sum and any in-flight beats; no result is produced for that vector.
- Accept condition: in_valid && in_ready at the rising edge.
- in_ready = !(last_s1 || last_s2 || (out_valid && !out_ready)); it is combinational from out_ready.
- Stage 1, at the accept edge E: product register loads the full 2N-bit signed in_a*in_b; last_s1 loads in_last.
- Stage 2, at edge E+1: accumulator loads acc + sign-extended product.
  - If the true sum exceeds the AW-bit signed range, the accumulator clamps to +max/-min and the sticky flag is set.
  - last_s2 follows last_s1.
- Stage 3, at edge E+2 when last_s2 is set:
  - r = (acc + 2^(Q-1)) >>> Q, arithmetic shift; rounding is half toward +inf.
  - r is clamped to [-2^(N-1), 2^(N-1)-1].
  - out_y = clamped r; out_overflow = sticky || clamp; out_valid=1.
  - Accumulator and sticky flag clear to 0 on the same edge.
- Latency: last beat accepted at edge E gives out_valid high from edge E+2.
- Throughput: 1 beat/cycle within a vector; 2 idle input cycles after each last beat.
- Output hold: out_y and out_overflow stay stable while out_valid && !out_ready.
  - out_valid drops at the edge where out_ready=1, unless a new result loads on that same edge.
- Single-beat vector (in_last on the first beat) is legal: result is the rounded product.
- Beats with in_valid=0 are bubbles; the accumulator is unchanged.
- in_a/in_b/in_last are ignored when not accepted.

Test Plan:
- Reset, then accept (0x0180, 0x0200, last=1), i.e. 1.5*2.0 -> out_valid 2 edges after accept, out_y=0x0300, out_overflow=0.
- Vector of 3 beats (0x0100,0x0100), (0xFE80,0x0200), (0x0040,0x0400), last on beat 3 (1 - 3 + 1) -> out_y=0xFF00 (-1.0), overflow=0; in_ready low for the 2 cycles after beat 3.
- Rounding: (0x0001,0x0080,last) -> out_y=0x0001; (0xFFFF,0x0080,last) -> out_y=0x0000.
- Saturation: 4 beats of (0x7FFF,0x7FFF), last on beat 4 -> out_y=0x7FFF, out_overflow=1; then (0x8000,0x7FFF,last) -> out_y=0x8000, out_overflow=1; next vector (0x0100,0x0100,last) -> 0x0100, overflow=0 (flag cleared).
- Backpressure: hold out_ready=0 for 5 cycles with the result 0x0300 pending -> out_y stable; in_ready=0 throughout. Raise out_ready -> in_ready=1 that cycle, and a next-vector beat accepted then completes correctly.
- Reset mid-operation: accept 2 non-last beats, assert rst for one cycle, then send (0x0100,0x0100,last) -> out_y=0x0100 with no stale contribution; out_valid never rose for the aborted vector.
